// File: rtl/inst_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_arb_pkg
// Description : Shared types and helpers for the instance round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Wrap with an explicit compare so non-power-of-2 requester counts work.
    function automatic int rr_next_idx(input int idx, input int num);
        return (idx == num - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : inst_rr_pick
// Description : Combinational round-robin picker: first eligible index at or
//               above ptr, wrapping from NUM_REQ-1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rr_pick
    import inst_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        onehot = found ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/inst_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : inst_rr_arbiter
// Description : Round-robin arbiter with hold timeout and per-requester block
//               mask. Optional grant/timeout counters: INST_RR_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rr_arbiter
    import inst_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEFAULT,
    parameter int IDX_W    = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               timeout_o,
    output logic [IDX_W-1:0]   timeout_idx_o
`ifdef INST_RR_ARB_STATS_EN
    ,
    output logic [15:0]        grant_cnt_o,
    output logic [15:0]        timeout_cnt_o
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    arb_state_e         state, nxt_state;
    logic [IDX_W-1:0]   ptr, nxt_ptr;
    logic [NUM_REQ-1:0] block_mask, nxt_mask;
    logic [HOLD_W-1:0]  hold_cnt, nxt_hold;
    logic [NUM_REQ-1:0] nxt_gnt;
    logic               nxt_gnt_valid;
    logic [IDX_W-1:0]   nxt_gnt_idx;
    logic               nxt_timeout;
    logic [IDX_W-1:0]   nxt_timeout_idx;

    logic [NUM_REQ-1:0] eligible;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    assign eligible = req_i & ~block_mask;

    inst_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .found    (pick_found),
        .idx      (pick_idx),
        .onehot   (pick_onehot)
    );

    always_comb begin
        nxt_state       = state;
        nxt_ptr         = ptr;
        nxt_mask        = block_mask & req_i;   // a dropped request unblocks itself
        nxt_hold        = hold_cnt;
        nxt_gnt         = gnt_o;
        nxt_gnt_valid   = gnt_valid_o;
        nxt_gnt_idx     = gnt_idx_o;
        nxt_timeout     = 1'b0;
        nxt_timeout_idx = timeout_idx_o;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    nxt_gnt       = pick_onehot;
                    nxt_gnt_valid = 1'b1;
                    nxt_gnt_idx   = pick_idx;
                    nxt_hold      = '0;
                    nxt_state     = GRANT;
                end
            end
            GRANT: begin
                // Release wins over a coincident timeout.
                if (!req_i[gnt_idx_o]) begin
                    nxt_gnt       = '0;
                    nxt_gnt_valid = 1'b0;
                    nxt_ptr       = IDX_W'(rr_next_idx(int'(gnt_idx_o), NUM_REQ));
                    nxt_state     = IDLE;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
                    nxt_gnt              = '0;
                    nxt_gnt_valid        = 1'b0;
                    nxt_timeout          = 1'b1;
                    nxt_timeout_idx      = gnt_idx_o;
                    nxt_mask[gnt_idx_o]  = 1'b1;
                    nxt_ptr              = IDX_W'(rr_next_idx(int'(gnt_idx_o), NUM_REQ));
                    nxt_state            = IDLE;
                end else if (MAX_HOLD != 0) begin
                    nxt_hold = hold_cnt + HOLD_W'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            block_mask    <= '0;
            hold_cnt      <= '0;
            gnt_o         <= '0;
            gnt_valid_o   <= 1'b0;
            gnt_idx_o     <= '0;
            timeout_o     <= 1'b0;
            timeout_idx_o <= '0;
        end else begin
            state         <= nxt_state;
            ptr           <= nxt_ptr;
            block_mask    <= nxt_mask;
            hold_cnt      <= nxt_hold;
            gnt_o         <= nxt_gnt;
            gnt_valid_o   <= nxt_gnt_valid;
            gnt_idx_o     <= nxt_gnt_idx;
            timeout_o     <= nxt_timeout;
            timeout_idx_o <= nxt_timeout_idx;
        end
    end

`ifdef INST_RR_ARB_STATS_EN
    // Saturating event counters: new grants and revocations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_o   <= '0;
            timeout_cnt_o <= '0;
        end else begin
            if (state == IDLE && pick_found && grant_cnt_o != 16'hFFFF) begin
                grant_cnt_o <= grant_cnt_o + 16'd1;
            end
            if (nxt_timeout && timeout_cnt_o != 16'hFFFF) begin
                timeout_cnt_o <= timeout_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_rr_arbiter
// Description : Self-checking bench: cycle reference model feeds an expected
//               queue; directed scenarios add targeted checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rr_arbiter;

    localparam int NR = 10;
    localparam int MH = 16;

    typedef struct packed {
        logic [NR-1:0] gnt;
        logic          valid;
        logic [3:0]    idx;
        logic          to;
        logic [3:0]    to_idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] gnt_o;
    logic          gnt_valid_o;
    logic [3:0]    gnt_idx_o;
    logic          timeout_o;
    logic [3:0]    timeout_idx_o;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t exp_q[$];

    // reference model state
    bit            m_gnt;
    int            m_idx, m_ptr, m_hold, m_to_idx;
    bit            m_to;
    logic [NR-1:0] m_mask;

    inst_rr_arbiter #(
        .NUM_REQ  (NR),
        .IDX_W    (4),
        .MAX_HOLD (MH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req),
        .gnt_o         (gnt_o),
        .gnt_valid_o   (gnt_valid_o),
        .gnt_idx_o     (gnt_idx_o),
        .timeout_o     (timeout_o),
        .timeout_idx_o (timeout_idx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: advances on every rising edge, pushes what the DUT must show.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_gnt = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
            m_to = 0; m_to_idx = 0; m_mask = '0;
            exp_q.delete();
        end else begin
            logic [NR-1:0] newmask;
            exp_t e;
            newmask = m_mask & req;
            m_to = 0;
            if (!m_gnt) begin
                for (int k = 0; k < NR; k++) begin
                    int c;
                    c = (m_ptr + k) % NR;
                    if (!m_gnt && req[c[3:0]] && !m_mask[c[3:0]]) begin
                        m_gnt = 1; m_idx = c; m_hold = 1;
                    end
                end
            end else if (!req[m_idx[3:0]]) begin
                m_gnt = 0;
                m_ptr = (m_idx + 1) % NR;
            end else if (m_hold == MH) begin
                m_gnt = 0; m_to = 1; m_to_idx = m_idx;
                newmask[m_idx[3:0]] = 1'b1;
                m_ptr = (m_idx + 1) % NR;
            end else begin
                m_hold++;
            end
            m_mask   = newmask;
            e.gnt    = m_gnt ? (NR'(1) << m_idx) : '0;
            e.valid  = m_gnt;
            e.idx    = m_idx[3:0];
            e.to     = m_to;
            e.to_idx = m_to_idx[3:0];
            exp_q.push_back(e);
        end
    end

    // Scoreboard: compare on the falling edge, away from the sampling edge.
    initial forever begin
        @(negedge clk);
        if (!rst && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_gnt",       gnt_o,         e.gnt);
            check("sb_valid",     gnt_valid_o,   e.valid);
            check("sb_idx",       gnt_idx_o,     e.idx);
            check("sb_timeout",   timeout_o,     e.to);
            if (e.to) check("sb_timeout_idx", timeout_idx_o, e.to_idx);
        end
    end

    task automatic wait_grant(output int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt_valid_o && n < 60);
        check("grant_seen", gnt_valid_o, 1);
        idx = gnt_valid_o ? int'(gnt_idx_o) : -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int held;

        // reset without any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_gnt",     gnt_o,       0);
        check("rst_valid",   gnt_valid_o, 0);
        check("rst_timeout", timeout_o,   0);
        check("rst_idx",     gnt_idx_o,   0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_gnt", gnt_o, 0);

        // single requester
        req = 10'h008;
        wait_grant(idx);
        check("single_idx", idx, 3);
        check("single_gnt", gnt_o, 10'h008);
        repeat (3) @(negedge clk);
        req = '0;
        @(negedge clk);
        check("single_rel", gnt_o, 0);
        req = 10'h008;
        @(negedge clk);
        check("single_regrant", gnt_o, 10'h008);
        req = '0;
        do_reset();

        // round-robin wrap
        req = 10'h3FF;
        for (int k = 0; k < 12; k++) begin
            wait_grant(idx);
            check($sformatf("rr_order_%0d", k), idx, k % NR);
            @(negedge clk);
            req = req & ~(NR'(1) << idx);
            @(negedge clk);
            check("rr_gap", gnt_valid_o, 0);
            req = 10'h3FF;
        end
        req = '0;
        do_reset();

        // timeout and block mask
        req = 10'h080;
        wait_grant(idx);
        check("to_first", idx, 7);
        req  = 10'h084;
        held = 1;
        while (gnt_o[7] && held < 40) begin
            @(negedge clk);
            if (gnt_o[7]) held++;
        end
        check("to_hold_len", held, MH);
        check("to_pulse",    timeout_o, 1);
        check("to_idx",      timeout_idx_o, 7);
        @(negedge clk);
        check("to_pulse_once", timeout_o, 0);
        wait_grant(idx);
        check("to_next", idx, 2);
        req = 10'h080;
        repeat (4) begin
            @(negedge clk);
            check("to_masked", gnt_o[7], 0);
        end
        req = '0;
        @(negedge clk);
        req = 10'h080;
        wait_grant(idx);
        check("to_regrant", idx, 7);
        req = '0;
        do_reset();

        // release on the same edge as the timeout
        req = 10'h010;
        wait_grant(idx);
        check("sim_first", idx, 4);
        repeat (MH - 1) @(negedge clk);
        check("sim_held", gnt_o, 10'h010);
        req = '0;
        @(negedge clk);
        check("sim_no_to", timeout_o, 0);
        check("sim_rel",   gnt_o, 0);
        req = 10'h010;
        wait_grant(idx);
        check("sim_regrant", idx, 4);
        req = '0;
        @(negedge clk);
        @(negedge clk);

        // reset mid-grant
        req = 10'h100;
        wait_grant(idx);
        check("mid_idx", idx, 8);
        #2 rst = 1'b1;
        #1;
        check("mid_async_gnt",   gnt_o, 0);
        check("mid_async_valid", gnt_valid_o, 0);
        req = 10'h102;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_grant(idx);
        check("post_rst_idx", idx, 1);
        repeat (3) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
